// File: rtl/inst_encode.sv
// RISC-V instruction encoder: turns a decoded request (opcode or LI pseudo-op, fields, 64-bit immediate)
// into one or two 32-bit instruction words, flagging illegal immediates and unsupported opcodes.
`timescale 1ns/1ps
module inst_encode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_opcode,
  input  logic        req_li,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic        out_last
);

  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;

  typedef enum logic [1:0] {IDLE, EMIT, EMIT2} state_t;

  state_t      state_reg, state_next;
  logic        live_reg;
  logic [31:0] inst_reg, word1_reg;
  logic        err_reg, last_reg;
  logic        load, advance;

  logic [31:0] enc_word0, enc_word1;
  logic        enc_err, enc_two;
  logic        fit_i, fit_b, fit_j, sx32, lo_zero;
  logic [19:0] li_hi;

  // Range checks: the value fits a signed N-bit field when all bits above N-1 equal the sign bit.
  assign fit_i   = (&req_imm[63:11]) | ~(|req_imm[63:11]);
  assign fit_b   = ((&req_imm[63:12]) | ~(|req_imm[63:12])) & ~req_imm[0];
  assign fit_j   = ((&req_imm[63:20]) | ~(|req_imm[63:20])) & ~req_imm[0];
  assign sx32    = (req_imm[63:32] == {32{req_imm[31]}});
  assign lo_zero = ~(|req_imm[11:0]);
  // Round the upper part so the sign-extended low 12 bits add back to the original value.
  assign li_hi   = req_imm[31:12] + {19'd0, req_imm[11]};

  always_comb begin
    enc_word0 = '0;
    enc_word1 = '0;
    enc_err   = 1'b0;
    enc_two   = 1'b0;
    if (req_li) begin
      if (!sx32) begin
        enc_err = 1'b1;
      end else if (li_hi == 20'd0) begin
        enc_word0 = {req_imm[11:0], 5'd0, 3'b000, req_rd, OP_IMM};
      end else begin
        enc_word0 = {li_hi, req_rd, OP_LUI};
        if (!lo_zero) begin
          enc_two   = 1'b1;
          enc_word1 = {req_imm[11:0], req_rd, 3'b000, req_rd, OP_IMM_32};
        end
      end
    end else begin
      case (req_opcode)
        OP_IMM, OP_LOAD, OP_JALR: begin
          if (fit_i) enc_word0 = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
          else       enc_err   = 1'b1;
        end
        OP_S: begin
          if (fit_i) enc_word0 = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], req_opcode};
          else       enc_err   = 1'b1;
        end
        OP_B: begin
          if (fit_b) enc_word0 = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                                  req_imm[4:1], req_imm[11], req_opcode};
          else       enc_err   = 1'b1;
        end
        OP_JAL: begin
          if (fit_j) enc_word0 = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, req_opcode};
          else       enc_err   = 1'b1;
        end
        OP_LUI: begin
          if (lo_zero && ~(|req_imm[63:32])) enc_word0 = {req_imm[31:12], req_rd, req_opcode};
          else                               enc_err   = 1'b1;
        end
        OP_AUIPC: begin
          if (lo_zero && sx32) enc_word0 = {req_imm[31:12], req_rd, req_opcode};
          else                 enc_err   = 1'b1;
        end
        default: enc_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    advance    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid && live_reg) begin
          state_next = EMIT;
          load       = 1'b1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_reg) begin
            state_next = IDLE;
          end else begin
            state_next = EMIT2;
            advance    = 1'b1;
          end
        end
      end
      EMIT2: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      live_reg  <= 1'b0;
      inst_reg  <= '0;
      word1_reg <= '0;
      err_reg   <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      live_reg  <= 1'b1;
      if (load) begin
        inst_reg  <= enc_word0;
        word1_reg <= enc_word1;
        err_reg   <= enc_err;
        last_reg  <= ~enc_two;
      end else if (advance) begin
        inst_reg <= word1_reg;
        last_reg <= 1'b1;
      end
    end
  end

  assign req_ready = live_reg && (state_reg == IDLE);
  assign out_valid = (state_reg != IDLE);
  assign out_inst  = inst_reg;
  assign out_err   = err_reg;
  assign out_last  = last_reg;

endmodule

// File: tb/tb_inst_encode.sv
// Self-checking bench for inst_encode: directed vector table, hand-written backpressure/reset sequences,
// and randomized requests checked against an arithmetic reference model plus an immediate round-trip.
`timescale 1ns/1ps
module tb_inst_encode;

  localparam bit [6:0] AUIPC = 7'b0010111, LUI = 7'b0110111, BR = 7'b1100011, JAL = 7'b1101111;
  localparam bit [6:0] JALR = 7'b1100111, LOAD = 7'b0000011, OPI = 7'b0010011, ST = 7'b0100011;
  localparam bit [6:0] OPIW = 7'b0011011;

  typedef struct {
    bit        li;
    bit [6:0]  op;
    bit [4:0]  rd, rs1, rs2;
    bit [2:0]  f3;
    bit [63:0] imm;
  } req_t;

  typedef struct {
    int        n;
    bit        err;
    bit [31:0] w0, w1;
  } exp_t;

  typedef struct {
    req_t r;
    exp_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [6:0]  req_opcode = '0;
  logic        req_li = 1'b0;
  logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [2:0]  req_funct3 = '0;
  logic [63:0] req_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        out_err, out_last;

  int n_tests = 0;
  int n_fail  = 0;
  int n_txn   = 0;

  inst_encode dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_li(req_li), .req_rd(req_rd), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_funct3(req_funct3), .req_imm(req_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Extract 'width' bits of v starting at 'from' and place them at 'to'.
  function automatic bit [31:0] fb(input longint v, input int from, input int width, input int to);
    return 32'(((v >>> from) & ((64'd1 << width) - 1)) << to);
  endfunction

  function automatic exp_t ref_model(input req_t r);
    exp_t   e;
    longint s, lo, hi;
    bit [31:0] regs;
    e.n = 1; e.err = 1'b0; e.w0 = '0; e.w1 = '0;
    s = longint'(r.imm);
    regs = fb(r.rs1, 0, 5, 15) | fb(r.f3, 0, 3, 12);
    if (r.li) begin
      if (s < -64'sd2147483648 || s > 64'sd2147483647) e.err = 1'b1;
      else begin
        lo = s & 64'hFFF;
        hi = ((s + 2048) >>> 12) & 64'hFFFFF;
        if (hi == 0) e.w0 = fb(lo, 0, 12, 20) | fb(r.rd, 0, 5, 7) | 32'(OPI);
        else begin
          e.w0 = fb(hi, 0, 20, 12) | fb(r.rd, 0, 5, 7) | 32'(LUI);
          if (lo != 0) begin
            e.n  = 2;
            e.w1 = fb(lo, 0, 12, 20) | fb(r.rd, 0, 5, 15) | fb(r.rd, 0, 5, 7) | 32'(OPIW);
          end
        end
      end
    end else begin
      case (r.op)
        OPI, LOAD, JALR:
          if (s >= -2048 && s <= 2047) e.w0 = fb(s, 0, 12, 20) | regs | fb(r.rd, 0, 5, 7) | 32'(r.op);
          else e.err = 1'b1;
        ST:
          if (s >= -2048 && s <= 2047)
            e.w0 = fb(s, 5, 7, 25) | fb(r.rs2, 0, 5, 20) | regs | fb(s, 0, 5, 7) | 32'(r.op);
          else e.err = 1'b1;
        BR:
          if (s >= -4096 && s <= 4094 && (s & 1) == 0)
            e.w0 = fb(s, 12, 1, 31) | fb(s, 5, 6, 25) | fb(r.rs2, 0, 5, 20) | regs |
                   fb(s, 1, 4, 8) | fb(s, 11, 1, 7) | 32'(r.op);
          else e.err = 1'b1;
        JAL:
          if (s >= -(64'sd1 << 20) && s <= (64'sd1 << 20) - 2 && (s & 1) == 0)
            e.w0 = fb(s, 20, 1, 31) | fb(s, 1, 10, 21) | fb(s, 11, 1, 20) | fb(s, 12, 8, 12) |
                   fb(r.rd, 0, 5, 7) | 32'(r.op);
          else e.err = 1'b1;
        LUI:
          if ((s & 64'hFFF) == 0 && s >= 0 && s <= 64'sd4294967295)
            e.w0 = fb(s, 12, 20, 12) | fb(r.rd, 0, 5, 7) | 32'(r.op);
          else e.err = 1'b1;
        AUIPC:
          if ((s & 64'hFFF) == 0 && s >= -64'sd2147483648 && s <= 64'sd2147483647)
            e.w0 = fb(s, 12, 20, 12) | fb(r.rd, 0, 5, 7) | 32'(r.op);
          else e.err = 1'b1;
        default: e.err = 1'b1;
      endcase
    end
    return e;
  endfunction

  // Immediate decoder for a single word, in the same value convention as req_imm.
  function automatic longint decode(input bit [31:0] w);
    case (w[6:0])
      ST:    return longint'($signed({w[31:25], w[11:7]}));
      BR:    return longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      JAL:   return longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      LUI:   return longint'({32'd0, w[31:12], 12'd0});
      AUIPC: return longint'($signed({w[31:12], 12'd0}));
      default: return longint'($signed(w[31:20]));
    endcase
  endfunction

  // Executes the LI word sequence with RV64 semantics to recover the loaded value.
  function automatic longint run_li(input bit [31:0] w0, input bit [31:0] w1, input int n);
    longint x;
    bit [31:0] t;
    x = 0;
    for (int k = 0; k < n; k++) begin
      t = (k == 0) ? w0 : w1;
      if (t[6:0] == LUI) x = longint'($signed({t[31:12], 12'd0}));
      else if (t[6:0] == OPI) x = decode(t);
      else begin
        bit [31:0] sum;
        sum = 32'(x + decode(t));
        x = longint'($signed(sum));
      end
    end
    return x;
  endfunction

  function automatic vec_t mk(input bit li, input bit [6:0] op, input bit [4:0] rd, input bit [4:0] rs1,
                              input bit [4:0] rs2, input bit [2:0] f3, input bit [63:0] imm,
                              input int n, input bit err, input bit [31:0] w0, input bit [31:0] w1);
    vec_t v;
    v.r.li = li; v.r.op = op; v.r.rd = rd; v.r.rs1 = rs1; v.r.rs2 = rs2; v.r.f3 = f3; v.r.imm = imm;
    v.e.n = n; v.e.err = err; v.e.w0 = w0; v.e.w1 = w1;
    return v;
  endfunction

  task automatic send(input req_t r);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("wait_ready", req_ready, 1'b1);
    req_li = r.li; req_opcode = r.op; req_rd = r.rd; req_rs1 = r.rs1; req_rs2 = r.rs2;
    req_funct3 = r.f3; req_imm = r.imm; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_imm = '1;
  endtask

  task automatic get_word(input int stall, output bit ok, output bit [31:0] inst,
                          output bit err, output bit last);
    int n = 0;
    out_ready = 1'b0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("wait_valid", out_valid, 1'b1);
    ok = out_valid; inst = out_inst; err = out_err; last = out_last;
    if (!ok) return;
    chk("busy_ready", req_ready, 1'b0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_inst", out_inst, inst);
      chk("hold_last", out_last, last);
      chk("hold_ready", req_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_txn(input req_t r, input exp_t e, input int stall, input bit rnd_stall);
    bit ok;
    bit err, last;
    bit [31:0] got[2];
    longint back;
    ok = 1'b0;
    got[0] = '0; got[1] = '0;
    send(r);
    for (int k = 0; k < e.n; k++) begin
      int st;
      st = (k == 0) ? stall : 0;
      if (rnd_stall) st = $urandom_range(0, 2);
      get_word(st, ok, got[k], err, last);
      if (!ok) break;
      chk("inst", got[k], (k == 0) ? e.w0 : e.w1);
      chk("err", err, e.err);
      chk("last", last, (k == e.n - 1));
    end
    @(negedge clk);
    chk("no_extra_word", out_valid, 1'b0);
    if (ok && !e.err) begin
      back = r.li ? run_li(got[0], got[1], e.n) : decode(got[0]);
      chk("roundtrip", back, r.imm);
    end
    n_txn++;
    $display("[TB] txn %0d li=%0b op=%07b imm=0x%016h words=%0d err=%0b inst0=0x%08h",
             n_txn, r.li, r.op, r.imm, e.n, e.err, got[0]);
  endtask

  function automatic req_t rand_req();
    req_t r;
    bit [6:0] ops[8];
    int k;
    ops = '{OPI, LOAD, JALR, ST, BR, JAL, LUI, AUIPC};
    k = $urandom_range(0, 9);
    r.rd = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom); r.f3 = 3'($urandom);
    r.li = 1'b0;
    r.op = 7'($urandom);
    r.imm = {$urandom, $urandom};
    if (k < 8) r.op = ops[k];
    case (k)
      0, 1, 2, 3: r.imm = 64'(longint'($urandom_range(0, 4095)) - 2048);
      4: r.imm = 64'(2 * longint'($urandom_range(0, 4095)) - 4096);
      5: r.imm = 64'(2 * longint'($urandom_range(0, 1048575)) - 1048576);
      6: r.imm = {32'd0, $urandom & 32'hFFFFF000};
      7: r.imm = 64'(longint'($signed($urandom & 32'hFFFFF000)));
      8: begin
        r.li = 1'b1;
        case ($urandom_range(0, 3))
          0: r.imm = 64'(longint'($urandom_range(0, 4095)) - 2048);
          1: r.imm = 64'(longint'($signed($urandom & 32'hFFFFF000)));
          default: r.imm = 64'(longint'($signed($urandom)));
        endcase
      end
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    req_t r;
    exp_t e;
    bit saw;

    tbl.push_back(mk(0, BR,   0, 1, 2, 0, 64'hFFFF_FFFF_FFFF_F000, 1, 0, 32'h80208063, 0));
    tbl.push_back(mk(1, 7'h00, 5, 7, 9, 5, 64'h0000_0000_1234_5678, 2, 0, 32'h123452B7, 32'h6782829B));
    tbl.push_back(mk(1, 7'h00, 5, 0, 0, 0, 64'h0000_0000_7FFF_F800, 2, 0, 32'h800002B7, 32'h8002829B));
    tbl.push_back(mk(0, JAL,  1, 0, 0, 0, 64'd3,                   1, 1, 0, 0));
    tbl.push_back(mk(0, OPI,  1, 2, 0, 0, 64'd2048,                1, 1, 0, 0));
    tbl.push_back(mk(1, 7'h00, 10, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 32'hFFF00513, 0));
    tbl.push_back(mk(1, 7'h7F, 1, 0, 0, 0, 64'h0000_0000_0000_1000, 1, 0, 32'h000010B7, 0));
    tbl.push_back(mk(0, LUI,  3, 0, 0, 0, 64'h0000_0000_8000_0000, 1, 0, 32'h800001B7, 0));
    tbl.push_back(mk(0, LUI,  3, 0, 0, 0, 64'hFFFF_FFFF_8000_0000, 1, 1, 0, 0));
    tbl.push_back(mk(0, AUIPC, 3, 0, 0, 0, 64'hFFFF_FFFF_8000_0000, 1, 0, 32'h80000197, 0));
    tbl.push_back(mk(0, ST,   0, 2, 8, 3, 64'hFFFF_FFFF_FFFF_FFF8, 1, 0, 32'hFE813C23, 0));
    tbl.push_back(mk(0, 7'b0110011, 1, 2, 3, 0, 64'd0,            1, 1, 0, 0));
    tbl.push_back(mk(0, JALR, 1, 5, 0, 0, 64'd2047,                1, 0, 32'h7FF280E7, 0));
    tbl.push_back(mk(0, JAL,  1, 3, 4, 0, 64'h0000_0000_000F_FFFE, 1, 0, 32'h7FFFF0EF, 0));
    tbl.push_back(mk(0, JAL,  0, 0, 0, 0, 64'hFFFF_FFFF_FFF0_0000, 1, 0, 32'h8000006F, 0));
    tbl.push_back(mk(1, 7'h00, 5, 0, 0, 0, 64'h0000_0000_8000_0000, 1, 1, 0, 0));
    tbl.push_back(mk(0, BR,   0, 0, 0, 0, 64'd4096,                1, 1, 0, 0));
    tbl.push_back(mk(0, BR,   0, 0, 0, 1, 64'd4094,                1, 0, 32'h7E001FE3, 0));
    tbl.push_back(mk(0, BR,   0, 0, 0, 0, 64'd1,                   1, 1, 0, 0));
    tbl.push_back(mk(0, LOAD, 5, 2, 0, 3, 64'hFFFF_FFFF_FFFF_F800, 1, 0, 32'h80013283, 0));

    // Reset asserted asynchronously before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_err", out_err, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    chk("rst_ready_clocked", req_ready, 1'b0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", req_ready, 1'b1);

    foreach (tbl[i]) run_txn(tbl[i].r, tbl[i].e, 0, 1'b0);

    // Backpressure on the first LI word for five cycles.
    run_txn(tbl[1].r, tbl[1].e, 5, 1'b0);

    // Reset while the second LI word is pending.
    send(tbl[1].r);
    begin
      bit ok, err, last;
      bit [31:0] w;
      get_word(0, ok, w, err, last);
      chk("pre_rst_word0", w, 32'h123452B7);
    end
    @(negedge clk);
    chk("emit2_valid", out_valid, 1'b1);
    chk("emit2_inst", out_inst, 32'h6782829B);
    chk("emit2_last", out_last, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_inst", out_inst, 32'd0);
    chk("midrst_last", out_last, 1'b0);
    chk("midrst_ready", req_ready, 1'b0);
    out_ready = 1'b1;
    @(negedge clk); #2 rst_n = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    out_ready = 1'b0;
    chk("no_word_after_reset", saw, 1'b0);
    chk("ready_after_midrst", req_ready, 1'b1);
    n_txn++;
    $display("[TB] txn %0d reset during second LI word, discarded=%0b", n_txn, !saw);

    for (int i = 0; i < 200; i++) begin
      r = rand_req();
      e = ref_model(r);
      run_txn(r, e, 0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_encode.md
INST_ENCODE -- requirements
Module: inst_encode

Interface
REQ-001 The block SHALL have the ports below, one clock domain; reset is asynchronous and active-low.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 req_valid  in  1  request present. req_ready  out  1  block can accept a request.
REQ-005 req_opcode  in  7  target opcode: 0010111 AUIPC, 0110111 LUI, 1100011 B, 1101111 JAL, 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 0100011 S.
REQ-006 req_li  in  1  load-immediate pseudo-op; when 1, req_opcode is ignored.
REQ-007 req_rd, req_rs1, req_rs2  in  5 each  register fields. req_funct3  in  3  funct3 field.
REQ-008 req_imm  in  64  immediate as a 64-bit value, using the same value convention the immediate decoder produces.
REQ-009 out_valid  out  1  instruction word valid. out_ready  in  1  consumer accepts.
REQ-010 out_inst  out  32  encoded instruction. out_err  out  1  request rejected. out_last  out  1  final word of this request.

Function
REQ-011 States SHALL be IDLE, EMIT, EMIT2; req_ready SHALL be 1 only in IDLE.
REQ-012 A request SHALL be accepted on a clock edge with req_valid=1 and req_ready=1; all request fields are captured at that edge.
REQ-013 out_valid SHALL rise on the edge after acceptance, giving one-cycle latency; IDLE->EMIT at acceptance.
REQ-014 While out_valid=1 and out_ready=0, out_inst, out_err and out_last SHALL hold stable.
REQ-015 A handshake (out_valid and out_ready) in EMIT with out_last=1 SHALL return to IDLE, with out_valid=0 the next cycle; with out_last=0 it SHALL go EMIT->EMIT2.
REQ-016 EMIT2 SHALL always have out_last=1; its handshake SHALL return to IDLE. A new request SHALL NOT be accepted in the same cycle as the final handshake.
REQ-017 Field placement SHALL be: rd in [11:7], rs1 in [19:15], rs2 in [24:20], funct3 in [14:12], opcode in [6:0]. Only the fields used by the format are written; unused bits are 0.
REQ-018 I/LOAD/JALR/OP-IMM SHALL place imm[11:0] in [31:20]. Legal range: -2048..2047.
REQ-019 S SHALL place imm[11:5] in [31:25] and imm[4:0] in [11:7]. Legal range: -2048..2047.
REQ-020 B SHALL place imm[12] in [31], imm[10:5] in [30:25], imm[4:1] in [11:8] and imm[11] in [7]. Legal range: -4096..4094, and imm[0] must be 0.
REQ-021 JAL SHALL place imm[20] in [31], imm[10:1] in [30:21], imm[11] in [20] and imm[19:12] in [19:12]. Legal range: -2^20..2^20-2, and imm[0] must be 0.
REQ-022 LUI SHALL require imm[11:0]=0 and imm[63:32]=0. AUIPC SHALL require imm[11:0]=0 and imm[63:32] equal to 32 copies of imm[31]. Both place imm[31:12] in [31:12].
REQ-023 LI SHALL require imm[63:32] equal to 32 copies of imm[31]. Derivation: lo = imm[11:0]; hi = (imm[31:12] + imm[11]) mod 2^20.
REQ-024 LI with hi=0 SHALL emit the single word ADDI rd,x0,lo (opcode 0010011, funct3 000).
REQ-025 LI with hi!=0 SHALL emit LUI rd,hi. If lo!=0 it SHALL follow with ADDIW rd,rd,lo (opcode 0011011, funct3 000); if lo=0 the LUI word is the last.
REQ-026 An illegal immediate or unsupported opcode SHALL produce one word with out_err=1, out_inst=0 and out_last=1.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately force: state IDLE, out_valid=0, out_err=0, out_last=0, out_inst=0.
REQ-028 With rst_n=0, req_ready SHALL be 0; it SHALL be 1 from the first edge after release.
REQ-029 Reset during EMIT or EMIT2 SHALL discard the pending word(s) without emitting them.

Verification
REQ-030 B, imm=-4096, rs1=1, rs2=2, funct3=000 -> one word, out_inst=0x80208063, out_last=1, out_err=0.
REQ-031 LI, rd=5, imm=0x12345678 -> words 0x123452B7 then 0x6782829B; out_last=0 then 1.
REQ-032 LI, rd=5, imm=0x7FFFF800 -> words 0x800002B7 then 0x8002829B; out_last=0 then 1.
REQ-033 JAL, imm=3 -> one word with out_err=1, out_inst=0. OP-IMM, imm=2048 -> out_err=1, out_inst=0.
REQ-034 Hold out_ready=0 for 5 cycles on the first LI word -> out_inst stable and req_ready=0 throughout.
REQ-035 Assert rst_n=0 while in EMIT2 -> out_valid=0 immediately, and no further word after release.
REQ-036 Round-trip: for random legal requests, passing out_inst through the immediate decoder SHALL return req_imm.
